mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/accelerator_pkg.sv | 27 ++
 rtl/arb_owner_fifo.sv | 64 ++++++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/accelerator_pkg.sv
// ============================================================================
// accelerator_pkg : shared types and limits for the memory-port arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package accelerator_pkg;

    typedef enum logic {
        ARB_OWNER_CORE = 1'b0,
        ARB_OWNER_VLSU = 1'b1
    } arb_owner_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_t;

    localparam int ARB_MAX_OUTSTANDING_MAX = 4;

    function automatic arb_owner_t arb_other(input arb_owner_t owner);
        return (owner == ARB_OWNER_CORE) ? ARB_OWNER_VLSU : ARB_OWNER_CORE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/arb_owner_fifo.sv
// ============================================================================
// arb_owner_fifo : in-order record of which requester owns each outstanding
//                  transaction. Revision 1.0
// ============================================================================
`default_nettype none

module arb_owner_fifo
    import accelerator_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       push_i,
    input  arb_owner_t owner_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output arb_owner_t head_o
);

    arb_owner_t mem_q [ARB_MAX_OUTSTANDING_MAX];
    logic [1:0] wr_q, rd_q;
    logic [2:0] cnt_q;
    logic       do_push, do_pop;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign full_o  = (cnt_q == 3'(DEPTH));
    assign empty_o = (cnt_q == 3'd0);
    assign head_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO can still accept a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_q  <= 2'd0;
            rd_q  <= 2'd0;
            cnt_q <= 3'd0;
            for (int i = 0; i < ARB_MAX_OUTSTANDING_MAX; i++) begin
                mem_q[i] <= ARB_OWNER_CORE;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= owner_i;
                wr_q        <= ptr_next(wr_q);
            end
            if (do_pop) begin
                rd_q <= ptr_next(rd_q);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 3'd1;
                2'b01:   cnt_q <= cnt_q - 3'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one OBI-style memory port between the scalar core
//                    LSU and the vector LSU. Revision 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import accelerator_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [3:0]  core_be_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    output logic        core_gnt_o,
    output logic        core_rvalid_o,
    output logic [31:0] core_rdata_o,
    input  logic        vlsu_req_i,
    input  logic        vlsu_we_i,
    input  logic [3:0]  vlsu_be_i,
    input  logic [31:0] vlsu_addr_i,
    input  logic [31:0] vlsu_wdata_i,
    output logic        vlsu_gnt_o,
    output logic        vlsu_rvalid_o,
    output logic [31:0] vlsu_rdata_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        core_halt_i,
    output logic        err_o
);

    arb_state_t state_q, state_d;
    arb_owner_t owner_q, owner_d;
    arb_owner_t rr_q, rr_d;
    arb_owner_t owner;
    arb_owner_t fifo_head;
    logic       err_q, err_d;
    logic       issue, owner_req, req, grant;
    logic       fifo_full, fifo_empty, fifo_pop;

    assign fifo_pop = data_rvalid_i && !fifo_empty;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ARB_IDLE;
            owner_q <= ARB_OWNER_CORE;
            rr_q    <= ARB_OWNER_CORE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        err_d   = err_q || (data_rvalid_i && fifo_empty);
        owner   = owner_q;
        issue   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (!fifo_full && (core_req_i || vlsu_req_i)) begin
                    issue = 1'b1;
                    if (core_req_i && vlsu_req_i) begin
                        owner = core_halt_i ? ARB_OWNER_VLSU : rr_q;
                    end else begin
                        owner = vlsu_req_i ? ARB_OWNER_VLSU : ARB_OWNER_CORE;
                    end
                end
            end
            ARB_HOLD: issue = 1'b1;
            default:  issue = 1'b0;
        endcase

        owner_req = (owner == ARB_OWNER_VLSU) ? vlsu_req_i : core_req_i;
        // Outputs are gated by n_reset so they drop the instant reset asserts.
        req   = issue && owner_req && n_reset;
        grant = req && data_gnt_i && (!fifo_full || fifo_pop);

        if (grant) begin
            state_d = ARB_IDLE;
            rr_d    = arb_other(owner);
        end else if (req) begin
            state_d = ARB_HOLD;
            owner_d = owner;
        end
    end

    arb_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push_i  (grant),
        .owner_i (owner),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    assign data_req_o   = req;
    assign data_we_o    = (owner == ARB_OWNER_VLSU) ? vlsu_we_i    : core_we_i;
    assign data_be_o    = (owner == ARB_OWNER_VLSU) ? vlsu_be_i    : core_be_i;
    assign data_addr_o  = (owner == ARB_OWNER_VLSU) ? vlsu_addr_i  : core_addr_i;
    assign data_wdata_o = (owner == ARB_OWNER_VLSU) ? vlsu_wdata_i : core_wdata_i;

    assign core_gnt_o    = grant && (owner == ARB_OWNER_CORE);
    assign vlsu_gnt_o    = grant && (owner == ARB_OWNER_VLSU);
    assign core_rvalid_o = fifo_pop && n_reset && (fifo_head == ARB_OWNER_CORE);
    assign vlsu_rvalid_o = fifo_pop && n_reset && (fifo_head == ARB_OWNER_VLSU);
    assign core_rdata_o  = data_rdata_i;
    assign vlsu_rdata_o  = data_rdata_i;
    assign err_o         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed and randomised checks of mem_port_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        c_req = 0, c_we = 0, v_req = 0, v_we = 0, halt = 0;
    logic [3:0]  c_be = 0, v_be = 0;
    logic [31:0] c_addr = 0, c_wdata = 0, v_addr = 0, v_wdata = 0;
    logic        dgnt = 0, drv = 0;
    logic [31:0] drdata = 0;
    logic        core_gnt, core_rvalid, vlsu_gnt, vlsu_rvalid;
    logic [31:0] core_rdata, vlsu_rdata;
    logic        data_req, data_we, err;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of owners awaiting responses (0=core, 1=vlsu).
    bit mq[$];
    bit pref, hold, hold_who, m_err;
    bit e_req, e_who, e_gnt, e_pop, e_head;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .n_reset(n_reset),
        .core_req_i(c_req), .core_we_i(c_we), .core_be_i(c_be),
        .core_addr_i(c_addr), .core_wdata_i(c_wdata),
        .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
        .vlsu_req_i(v_req), .vlsu_we_i(v_we), .vlsu_be_i(v_be),
        .vlsu_addr_i(v_addr), .vlsu_wdata_i(v_wdata),
        .vlsu_gnt_o(vlsu_gnt), .vlsu_rvalid_o(vlsu_rvalid), .vlsu_rdata_o(vlsu_rdata),
        .data_req_o(data_req), .data_we_o(data_we), .data_be_o(data_be),
        .data_addr_o(data_addr), .data_wdata_o(data_wdata),
        .data_gnt_i(dgnt), .data_rvalid_i(drv), .data_rdata_i(drdata),
        .core_halt_i(halt), .err_o(err)
    );

    task automatic predict();
        bit full;
        full   = (mq.size() >= MAXO);
        e_pop  = drv && (mq.size() > 0);
        e_head = (mq.size() > 0) ? mq[0] : 1'b0;
        e_req  = 0; e_who = 0; e_gnt = 0;
        if (hold) begin
            e_req = 1; e_who = hold_who; e_gnt = dgnt && (!full || e_pop);
        end else if (!full && (c_req || v_req)) begin
            e_req = 1;
            e_who = (c_req && v_req) ? (halt ? 1'b1 : pref) : v_req;
            e_gnt = dgnt;
        end
    endtask

    task automatic tick();
        predict();
        @(posedge clk);
        if (drv && mq.size() == 0) m_err = 1;
        if (e_pop) void'(mq.pop_front());
        if (e_gnt) begin
            mq.push_back(e_who); pref = ~e_who; hold = 0;
        end else if (e_req) begin
            hold = 1; hold_who = e_who;
        end
        #1;
    endtask

    task automatic clear_inputs();
        c_req = 0; v_req = 0; halt = 0; dgnt = 0; drv = 0;
        c_we = 0; v_we = 0; c_be = 4'hF; v_be = 4'hF;
    endtask

    task automatic apply_reset();
        clear_inputs();
        n_reset = 0;
        mq.delete(); pref = 0; hold = 0; hold_who = 0; m_err = 0;
        @(posedge clk); @(posedge clk); #1;
        n_reset = 1;
    endtask

    task automatic test_reset();
        n_reset = 0; c_req = 1; v_req = 1; dgnt = 1; drv = 1;
        #1;
        checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", data_req); end
        checks++; if ({core_gnt, vlsu_gnt, core_rvalid, vlsu_rvalid} !== 4'b0) begin errors++;
            $display("FAIL reset_gnt_rvalid: got %b want 0000", {core_gnt, vlsu_gnt, core_rvalid, vlsu_rvalid}); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        apply_reset();
    endtask

    task automatic test_single_read();
        apply_reset();
        c_req = 1; c_addr = 32'h100; dgnt = 1;
        @(negedge clk);
        checks++; if (core_gnt !== 1'b1 || vlsu_gnt !== 1'b0) begin errors++;
            $display("FAIL single_gnt: got core=%b vlsu=%b want 1/0", core_gnt, vlsu_gnt); end
        checks++; if (data_addr !== 32'h100) begin errors++; $display("FAIL single_addr: got %h want 100", data_addr); end
        tick();
        c_req = 0; dgnt = 0;
        tick();
        drv = 1; drdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (core_rvalid !== 1'b1 || core_rdata !== 32'hDEADBEEF || vlsu_rvalid !== 1'b0) begin errors++;
            $display("FAIL single_rvalid: got rv=%b data=%h vrv=%b want 1/deadbeef/0", core_rvalid, core_rdata, vlsu_rvalid); end
        tick();
        drv = 0;
    endtask

    task automatic test_contention();
        bit order [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        apply_reset();
        c_req = 1; v_req = 1; c_addr = 32'hA0; v_addr = 32'hB0; dgnt = 1;
        for (int i = 0; i < 4; i++) begin
            drv = (i > 0);
            @(negedge clk);
            checks++; if (core_gnt !== !order[i] || vlsu_gnt !== order[i]) begin errors++;
                $display("FAIL contention_%0d: got core=%b vlsu=%b want vlsu=%b", i, core_gnt, vlsu_gnt, order[i]); end
            tick();
        end
        clear_inputs();
        drv = 1; tick(); drv = 0;
    endtask

    task automatic test_hold();
        apply_reset();
        c_req = 1; v_req = 1; c_addr = 32'h1000; v_addr = 32'h2000; halt = 1; dgnt = 0;
        for (int i = 0; i < 3; i++) begin
            halt = (i != 1);
            @(negedge clk);
            checks++; if (data_addr !== 32'h2000 || data_req !== 1'b1 || core_gnt !== 1'b0 || vlsu_gnt !== 1'b0) begin errors++;
                $display("FAIL hold_%0d: got addr=%h req=%b gnt=%b%b want 2000/1/00", i, data_addr, data_req, core_gnt, vlsu_gnt); end
            tick();
        end
        halt = 0; dgnt = 1;
        @(negedge clk);
        checks++; if (vlsu_gnt !== 1'b1 || core_gnt !== 1'b0) begin errors++;
            $display("FAIL hold_release: got vlsu=%b core=%b want 1/0", vlsu_gnt, core_gnt); end
        tick();
    endtask

    task automatic test_fifo_full();
        apply_reset();
        c_req = 1; dgnt = 1; tick();
        c_req = 0; v_req = 1; tick();
        c_req = 1;
        @(negedge clk);
        checks++; if (data_req !== 1'b0 || core_gnt !== 1'b0 || vlsu_gnt !== 1'b0) begin errors++;
            $display("FAIL full_block: got req=%b gnt=%b%b want 0/00", data_req, core_gnt, vlsu_gnt); end
        tick();
        c_req = 0; v_req = 0; drv = 1;
        @(negedge clk);
        checks++; if (core_rvalid !== 1'b1 || vlsu_rvalid !== 1'b0) begin errors++;
            $display("FAIL full_pop1: got c=%b v=%b want 1/0", core_rvalid, vlsu_rvalid); end
        tick();
        @(negedge clk);
        checks++; if (core_rvalid !== 1'b0 || vlsu_rvalid !== 1'b1) begin errors++;
            $display("FAIL full_pop2: got c=%b v=%b want 0/1", core_rvalid, vlsu_rvalid); end
        tick();
        @(negedge clk);
        checks++; if (core_rvalid !== 1'b0 || vlsu_rvalid !== 1'b0) begin errors++;
            $display("FAIL full_empty_rv: got c=%b v=%b want 0/0", core_rvalid, vlsu_rvalid); end
        tick();
        drv = 0;
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL full_count0_err: got %b want 1", err); end
    endtask

    task automatic test_push_pop();
        apply_reset();
        c_req = 1; dgnt = 1; tick();
        c_req = 0; v_req = 1; drv = 1;
        @(negedge clk);
        checks++; if (vlsu_gnt !== 1'b1 || core_rvalid !== 1'b1 || vlsu_rvalid !== 1'b0) begin errors++;
            $display("FAIL pushpop_same: got vgnt=%b crv=%b vrv=%b want 1/1/0", vlsu_gnt, core_rvalid, vlsu_rvalid); end
        tick();
        v_req = 0;
        @(negedge clk);
        checks++; if (vlsu_rvalid !== 1'b1 || core_rvalid !== 1'b0) begin errors++;
            $display("FAIL pushpop_next: got vrv=%b crv=%b want 1/0", vlsu_rvalid, core_rvalid); end
        tick();
        drv = 0; tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL pushpop_noerr: got %b want 0", err); end
    endtask

    task automatic test_error_reset();
        apply_reset();
        drv = 1; tick(); drv = 0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err); end
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
        c_req = 1; c_addr = 32'h300; dgnt = 0; tick();
        dgnt = 1; #2;
        n_reset = 0; #1;
        checks++; if (data_req !== 1'b0 || core_gnt !== 1'b0 || vlsu_gnt !== 1'b0 || err !== 1'b0) begin errors++;
            $display("FAIL reset_mid_hold: got req=%b gnt=%b%b err=%b want 0/00/0", data_req, core_gnt, vlsu_gnt, err); end
        apply_reset();
    endtask

    task automatic test_random();
        int bad = 0;
        apply_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!c_req || (e_gnt && !e_who && cyc > 0)) begin
                c_req = $urandom_range(0, 1); c_addr = $urandom; c_we = $urandom_range(0, 1);
                c_be = 4'($urandom); c_wdata = $urandom;
            end
            if (!v_req || (e_gnt && e_who && cyc > 0)) begin
                v_req = $urandom_range(0, 1); v_addr = $urandom; v_we = $urandom_range(0, 1);
                v_be = 4'($urandom); v_wdata = $urandom;
            end
            halt = ($urandom_range(0, 3) == 0);
            dgnt = ($urandom_range(0, 2) != 0);
            drv = (mq.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 31) == 0);
            drdata = $urandom;
            @(negedge clk);
            predict();
            checks++;
            if (data_req !== e_req || core_gnt !== (e_gnt && !e_who) || vlsu_gnt !== (e_gnt && e_who) ||
                core_rvalid !== (e_pop && !e_head) || vlsu_rvalid !== (e_pop && e_head) ||
                err !== m_err || core_rdata !== drdata || vlsu_rdata !== drdata ||
                (e_req && data_addr !== (e_who ? v_addr : c_addr))) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL random_%0d: got req=%b gnt=%b%b rv=%b%b err=%b want req=%b who=%b gnt=%b pop=%b head=%b err=%b",
                    cyc, data_req, core_gnt, vlsu_gnt, core_rvalid, vlsu_rvalid, err, e_req, e_who, e_gnt, e_pop, e_head, m_err);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_hold();
        test_fifo_full();
        test_push_pop();
        test_error_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
